// File: rtl/iomem_arbiter_if.sv
// iomem valid/ready bus bundle: one request channel with a completion strobe and read data.
interface iomem_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  // Side that issues requests
  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  // Side that services requests
  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the shared iomem port, with a hung-transaction timeout.
module iomem_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1024  // granted stall cycles before abort; 0 disables
) (
  input  logic                   clk,
  input  logic                   reset,
  iomem_arbiter_if.slave         m0,
  iomem_arbiter_if.slave         m1,
  iomem_arbiter_if.master        s,
  output logic [1:0]             grant,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StAbort} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 0 = m0, 1 = m1; doubles as last_owner for fairness
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;

  // Request of the current owner; owner_q is always the granted master while not idle
  logic        own_valid;
  logic [31:0] own_addr, own_wdata;
  logic [3:0]  own_wstrb;

  // Select the owning master's request fields
  always_comb begin
    own_valid = owner_q ? m1.valid : m0.valid;
    own_addr  = owner_q ? m1.addr  : m0.addr;
    own_wdata = owner_q ? m1.wdata : m0.wdata;
    own_wstrb = owner_q ? m1.wstrb : m0.wstrb;
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 1'b1;
      count_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Next-state: arbitration, completion, protocol drop and timeout
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        // On contention m0 wins only if m1 owned the bus last
        if (m0.valid && (!m1.valid || owner_q)) begin
          state_d = StGnt0;
          owner_d = 1'b0;
          count_d = 16'd0;
        end else if (m1.valid) begin
          state_d = StGnt1;
          owner_d = 1'b1;
          count_d = 16'd0;
        end
      end
      StGnt0, StGnt1: begin
        // Completion takes priority over an abort due in the same cycle
        if (s.ready || !own_valid) begin
          state_d = StIdle;
        end else begin
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (TIMEOUT != 16'd0 && count_q == TIMEOUT - 16'd1) state_d = StAbort;
        end
      end
      StAbort: begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: bus mux and ready/rdata routing, decoded from the registered state only
  always_comb begin
    grant    = 2'b00;
    s.valid  = 1'b0;
    s.addr   = 32'd0;
    s.wdata  = 32'd0;
    s.wstrb  = 4'd0;
    m0.ready = 1'b0;
    m0.rdata = 32'd0;
    m1.ready = 1'b0;
    m1.rdata = 32'd0;
    unique case (state_q)
      StGnt0, StGnt1: begin
        grant   = owner_q ? 2'b10 : 2'b01;
        s.valid = own_valid;
        s.addr  = own_addr;
        s.wdata = own_wdata;
        s.wstrb = own_wstrb;
        if (owner_q) begin
          m1.ready = s.ready;
          m1.rdata = s.rdata;
        end else begin
          m0.ready = s.ready;
          m0.rdata = s.rdata;
        end
      end
      StAbort: begin
        // Slave is dropped; owner gets a synthetic completion with all-ones data
        grant   = owner_q ? 2'b10 : 2'b01;
        s.addr  = own_addr;
        s.wdata = own_wdata;
        s.wstrb = own_wstrb;
        if (owner_q) begin
          m1.ready = 1'b1;
          m1.rdata = 32'hFFFF_FFFF;
        end else begin
          m0.ready = 1'b1;
          m0.rdata = 32'hFFFF_FFFF;
        end
      end
      default: ;
    endcase
  end

  assign timeout_err = err_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Self-checking bench for iomem_arbiter: directed scenarios followed by randomized traffic.
module tb_iomem_arbiter;

  localparam logic [15:0] TO = 16'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  grant;
  logic        timeout_err;

  iomem_arbiter_if m0_if ();
  iomem_arbiter_if m1_if ();
  iomem_arbiter_if s_if ();

  // Master and slave stimulus, indexed by master number
  logic        mv [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  logic        sr;
  logic [31:0] srd;

  assign m0_if.valid = mv[0];
  assign m0_if.addr  = ma[0];
  assign m0_if.wdata = mw[0];
  assign m0_if.wstrb = ms[0];
  assign m1_if.valid = mv[1];
  assign m1_if.addr  = ma[1];
  assign m1_if.wdata = mw[1];
  assign m1_if.wstrb = ms[1];
  assign s_if.ready  = sr;
  assign s_if.rdata  = srd;

  always #5 clk = ~clk;

  iomem_arbiter #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who holds the bus, how long it has stalled, whether it is being aborted
  int owner    = -1;
  int last     = 1;
  int waited   = 0;
  bit aborting = 1'b0;
  bit err      = 1'b0;
  bit exp_ready [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; last = 1; waited = 0; aborting = 1'b0; err = 1'b0;
  endtask

  task automatic set_m(input int i, input logic v, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s);
    mv[i] = v; ma[i] = a; mw[i] = w; ms[i] = s;
  endtask

  // Called at the falling edge after inputs are set: compare every output against the model
  task automatic settle();
    logic [1:0]  eg;
    logic        esv;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    logic [31:0] erd [2];
    bit          bus_known;
    #1;
    eg = 2'b00; esv = 1'b0; ea = 32'd0; ew = 32'd0; es = 4'd0;
    erd[0] = 32'd0; erd[1] = 32'd0;
    exp_ready[0] = 1'b0; exp_ready[1] = 1'b0;
    bus_known = 1'b1;
    if (owner >= 0) begin
      eg = (owner == 0) ? 2'b01 : 2'b10;
      if (aborting) begin
        exp_ready[owner] = 1'b1;
        erd[owner]       = 32'hFFFF_FFFF;
        bus_known        = 1'b0;
      end else begin
        esv              = mv[owner];
        ea               = ma[owner];
        ew               = mw[owner];
        es               = ms[owner];
        exp_ready[owner] = sr;
        erd[owner]       = srd;
      end
    end
    chk("grant", {30'd0, grant}, {30'd0, eg});
    chk("s_valid", {31'd0, s_if.valid}, {31'd0, esv});
    if (bus_known) begin
      chk("s_addr", s_if.addr, ea);
      chk("s_wdata", s_if.wdata, ew);
      chk("s_wstrb", {28'd0, s_if.wstrb}, {28'd0, es});
    end
    chk("m0_ready", {31'd0, m0_if.ready}, {31'd0, exp_ready[0]});
    chk("m1_ready", {31'd0, m1_if.ready}, {31'd0, exp_ready[1]});
    chk("m0_rdata", m0_if.rdata, erd[0]);
    chk("m1_rdata", m1_if.rdata, erd[1]);
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, err});
  endtask

  // Apply the arbitration rules to this cycle's inputs, then move to the next falling edge
  task automatic advance();
    if (owner < 0) begin
      if (mv[0] && mv[1]) owner = 1 - last;
      else if (mv[0])     owner = 0;
      else if (mv[1])     owner = 1;
      if (owner >= 0) begin
        last   = owner;
        waited = 0;
      end
    end else if (aborting) begin
      err = 1'b1; aborting = 1'b0; owner = -1;
    end else if (sr) begin
      owner = -1;
    end else if (!mv[owner]) begin
      owner = -1;
    end else begin
      if (waited < 65535) waited++;
      if (TO != 16'd0 && waited == int'(TO)) aborting = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_m(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_m(1, 1'b0, 32'd0, 32'd0, 4'd0);
    sr = 1'b0; srd = 32'd0;
    #2;
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_s_valid", {31'd0, s_if.valid}, 32'd0);
    chk("rst_s_addr", s_if.addr, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend [2];
    bit stuck;
    pend[0] = 1'b0; pend[1] = 1'b0;

    do_reset();

    // m0 read, slave answers two cycles after s_valid
    set_m(0, 1'b1, 32'h0300_0000, 32'd0, 4'd0);
    tick();
    settle(); chk("t1_grant", {30'd0, grant}, 32'h1); advance();
    tick();
    sr = 1'b1; srd = 32'h1234_5678;
    settle();
    chk("t1_ready", {31'd0, m0_if.ready}, 32'h1);
    chk("t1_rdata", m0_if.rdata, 32'h1234_5678);
    advance();
    mv[0] = 1'b0; sr = 1'b0;
    settle(); chk("t1_idle", {30'd0, grant}, 32'h0); advance();

    // Both masters request from the first post-reset cycle; grants must alternate
    do_reset();
    set_m(0, 1'b1, 32'h0300_0010, 32'd0, 4'd0);
    set_m(1, 1'b1, 32'h0300_0020, 32'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      sr = 1'b0;
      settle(); chk("t2_idle", {30'd0, grant}, 32'h0); advance();
      settle(); chk("t2_grant", {30'd0, grant}, (i % 2 == 0) ? 32'h1 : 32'h2); advance();
      sr = 1'b1; srd = 32'h5000_0000 + i;
      settle();
      chk("t2_m0_ready", {31'd0, m0_if.ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("t2_m1_ready", {31'd0, m1_if.ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
      advance();
    end
    mv[0] = 1'b0; mv[1] = 1'b0; sr = 1'b0;
    tick();

    // m1 write with partial strobes
    set_m(1, 1'b1, 32'h0300_0100, 32'hCAFE_F00D, 4'b0011);
    tick();
    settle();
    chk("t3_wdata", s_if.wdata, 32'hCAFE_F00D);
    chk("t3_wstrb", {28'd0, s_if.wstrb}, 32'h3);
    chk("t3_m0_ready", {31'd0, m0_if.ready}, 32'h0);
    advance();
    sr = 1'b1;
    settle(); chk("t3_m1_ready", {31'd0, m1_if.ready}, 32'h1); advance();
    mv[1] = 1'b0; sr = 1'b0;
    tick();

    // m0 drops valid mid-transaction: back to idle, no ready, no error
    set_m(0, 1'b1, 32'h0300_0200, 32'd0, 4'd0);
    tick();
    tick();
    mv[0] = 1'b0;
    settle(); chk("t4_drop_ready", {31'd0, m0_if.ready}, 32'h0); advance();
    settle(); chk("t4_drop_idle", {30'd0, grant}, 32'h0); advance();

    // Slave never answers: exactly TO cycles of s_valid, then the abort pulse
    set_m(0, 1'b1, 32'h0300_0300, 32'd0, 4'd0);
    tick();
    for (int i = 0; i < int'(TO); i++) begin
      settle(); chk("t5_s_valid", {31'd0, s_if.valid}, 32'h1); advance();
    end
    settle();
    chk("t5_abort_valid", {31'd0, s_if.valid}, 32'h0);
    chk("t5_abort_ready", {31'd0, m0_if.ready}, 32'h1);
    chk("t5_abort_rdata", m0_if.rdata, 32'hFFFF_FFFF);
    advance();
    mv[0] = 1'b0;
    settle(); chk("t5_err", {31'd0, timeout_err}, 32'h1); advance();
    set_m(1, 1'b1, 32'h0300_0400, 32'h1, 4'hF);
    tick();
    sr = 1'b1;
    settle(); chk("t5_good_ready", {31'd0, m1_if.ready}, 32'h1); advance();
    mv[1] = 1'b0; sr = 1'b0;
    settle(); chk("t5_err_sticky", {31'd0, timeout_err}, 32'h1); advance();

    // Slave answers in the last granted cycle before the limit: completion wins
    do_reset();
    set_m(0, 1'b1, 32'h0300_0500, 32'd0, 4'd0);
    srd = 32'hAABB_CCDD;
    tick();
    for (int i = 0; i < int'(TO) - 1; i++) tick();
    sr = 1'b1;
    settle();
    chk("t6_ready", {31'd0, m0_if.ready}, 32'h1);
    chk("t6_rdata", m0_if.rdata, 32'hAABB_CCDD);
    advance();
    mv[0] = 1'b0; sr = 1'b0;
    settle();
    chk("t6_err", {31'd0, timeout_err}, 32'h0);
    chk("t6_idle", {30'd0, grant}, 32'h0);
    advance();

    // Asynchronous reset while m1 holds the bus
    set_m(1, 1'b1, 32'h0300_0600, 32'd0, 4'd0);
    tick();
    settle(); chk("t7_pre_grant", {30'd0, grant}, 32'h2); advance();
    settle();
    sr = 1'b1;
    reset = 1'b1;
    #1;
    chk("t7_async_valid", {31'd0, s_if.valid}, 32'h0);
    chk("t7_async_ready", {31'd0, m1_if.ready}, 32'h0);
    chk("t7_async_grant", {30'd0, grant}, 32'h0);
    model_reset();
    sr = 1'b0;
    set_m(0, 1'b1, 32'h0300_0700, 32'd0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    settle(); chk("t7_first_grant", {30'd0, grant}, 32'h1); advance();
    sr = 1'b1;
    tick();
    mv[0] = 1'b0; mv[1] = 1'b0; sr = 1'b0;
    tick();

    // Randomized traffic, with periodic stretches where the slave is stuck
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stuck = ((cyc / 400) % 3 == 2);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          set_m(i, 1'b1, $urandom, $urandom, 4'($urandom));
        end
        mv[i] = pend[i];
      end
      sr  = stuck ? 1'b0 : ($urandom_range(0, 2) == 0);
      srd = $urandom;
      settle();
      for (int i = 0; i < 2; i++) if (exp_ready[i]) pend[i] = 1'b0;
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iomem_arbiter.md
# iomem_arbiter

Two-master arbiter that shares the SoC's single external iomem port (valid/ready memory bus: addr, wdata, wstrb, rdata) between the CPU and a second bus master such as a DMA or debug engine. It sits between the masters and the iomem pins. It grants one transaction at a time with round-robin fairness and holds the grant until the slave completes. A timeout aborts hung transactions so neither master can lock up the bus.

## Interface
- TIMEOUT, 16'd1024: granted cycles without s_ready before abort; 0 disables timeout; legal range 0..65535.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- m0_valid / m1_valid  in  1  master request, held until ready.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 = read.
- m0_ready / m1_ready  out  1  completion strobe to master, one cycle.
- m0_rdata / m1_rdata  out  32  read data, valid while own ready=1.
- s_valid  out  1  request to slave.
- s_addr, s_wdata  out  32  muxed from granted master.
- s_wstrb  out  4  muxed from granted master.
- s_rdata  in  32  slave read data.
- s_ready  in  1  slave completion.
- grant  out  2  one-hot current owner; 2'b00 = none.
- timeout_err  out  1  sticky; set on any abort, cleared only by reset.

## Operation
- States: IDLE, GNT0, GNT1, ABORT. Reset → IDLE, last_owner=1, count=0, timeout_err=0.
- Reset values: all outputs 0; s_addr, s_wdata, s_wstrb are 0 whenever grant=0.
- IDLE:
  - m0_valid only → GNT0; m1_valid only → GNT1.
  - Both valid → grant the master ≠ last_owner.
  - Set last_owner to the granted master; clear count.
- GNTx:
  - s_valid=mx_valid.
  - s_addr, s_wdata, s_wstrb come from mx.
  - mx_ready=s_ready and mx_rdata=s_rdata (combinational pass-through).
  - The other master sees ready=0 and rdata=0.
- GNTx, s_ready=1 → IDLE (transaction complete).
- GNTx, mx_valid drops without s_ready (protocol violation) → IDLE; no ready is issued; timeout_err is unchanged.
- GNTx, s_ready=0, mx_valid=1:
  - count increments (16-bit, saturating).
  - If TIMEOUT≠0 and count==TIMEOUT-1 → ABORT.
- ABORT (one cycle):
  - s_valid=0; mx_ready=1; mx_rdata=32'hFFFF_FFFF; timeout_err←1; → IDLE.
- s_ready is ignored in IDLE and ABORT.
- s_ready=1 in the same cycle the count reaches its limit → completion wins; no abort.
- A non-granted master's request waits and is never dropped.
- Fairness: with both masters continuously requesting, grants strictly alternate.

## Timing
- Request at IDLE cycle N → grant and s_valid at N+1.
- s_ready at cycle M → mx_ready at M (zero added latency); IDLE at M+1; next grant at M+2 at earliest.
- Single-master back-to-back throughput: one transaction per slave latency + 2 cycles.
- Abort: if s_ready never arrives, s_valid is high for TIMEOUT cycles, then mx_ready pulses in the following cycle (ABORT).
- Reset asserted mid-transaction: s_valid and both readys fall immediately (asynchronous). The interrupted transaction is lost. After release, the first grant is evaluated from IDLE.
- grant changes only on clock edges; it never glitches within a cycle.

## Test plan
- m0 only, read addr 32'h0300_0000; slave returns 32'h1234_5678 with s_ready 2 cycles after s_valid → grant=01 one cycle after request; m0_ready pulses once with m0_rdata=32'h1234_5678; grant=00 next cycle.
- m0 and m1 both assert valid in the first cycle after reset; slave has 1-cycle latency → grant order m0, m1, m0, m1; each completion is followed by one IDLE cycle; no ready goes to the wrong master.
- m1 writes wdata 32'hCAFE_F00D, wstrb 4'b0011 while m0 is idle → s_wdata and s_wstrb match exactly during grant; m0_ready stays 0.
- TIMEOUT=8, slave never readies → s_valid high for exactly 8 cycles; m0_ready=1 with rdata 32'hFFFF_FFFF; timeout_err=1 and remains 1 through later good transactions.
- TIMEOUT=8, s_ready arrives in the 8th granted cycle → normal completion with slave data; timeout_err stays 0.
- Reset pulsed while grant=10 and s_valid=1 → s_valid, m1_ready and grant go to 0 without a clock edge. After release with both masters requesting, m0 is granted first.
